// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, drives a single-
//               outstanding req/ack instruction-memory port and the IF/ID
//               pipeline register. Handles hazard stalls and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    // BOOT: idle cycle after reset; REQ: live fetch at pc;
    // HOLD: fetched word parked while decode is stalled;
    // DROP: cancelled request kept alive until its ack returns.
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_drop_addr_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [31:0] w_hold_pc_nxt;
    logic        w_id_valid_nxt;
    logic [31:0] w_id_instr_nxt;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] w_id_pc_plus4_nxt;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_hold_pc_plus4;
    logic        w_ack;

    // Only REQ and DROP present a request; DROP replays the cancelled address
    assign imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
    assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign w_target        = {redirect_pc[31:2], 2'b00};
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_hold_pc_plus4 = r_hold_pc + 32'd4;
    assign w_ack           = imem_ack && imem_req;

    assign id_valid       = r_id_valid;
    assign id_instruction = r_id_instr;
    assign id_pc          = r_id_pc;
    assign id_pc_plus4    = r_id_pc_plus4;

    // Next-state and next-register values; redirect outranks ack and stall
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_addr_nxt   = r_drop_addr;
        w_hold_instr_nxt  = r_hold_instr;
        w_hold_pc_nxt     = r_hold_pc;
        w_id_valid_nxt    = r_id_valid;
        w_id_instr_nxt    = r_id_instr;
        w_id_pc_nxt       = r_id_pc;
        w_id_pc_plus4_nxt = r_id_pc_plus4;

        if (redirect) begin
            // Squash whatever is in IF/ID and the parked word
            w_pc_nxt         = w_target;
            w_id_valid_nxt   = 1'b0;
            w_id_instr_nxt   = NOP_INSTR;
            w_hold_instr_nxt = NOP_INSTR;
            w_hold_pc_nxt    = 32'd0;
            case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_addr_nxt = r_pc;
                        w_state_nxt     = S_DROP;
                    end
                end
                S_DROP:  w_state_nxt = S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (w_ack) begin
                        w_pc_nxt = w_pc_plus4;
                        if (!stall) begin
                            w_id_valid_nxt    = 1'b1;
                            w_id_instr_nxt    = imem_rdata;
                            w_id_pc_nxt       = r_pc;
                            w_id_pc_plus4_nxt = w_pc_plus4;
                        end else begin
                            w_hold_instr_nxt = imem_rdata;
                            w_hold_pc_nxt    = r_pc;
                            w_state_nxt      = S_HOLD;
                        end
                    end else if (!stall) begin
                        w_id_valid_nxt = 1'b0;
                        w_id_instr_nxt = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_id_valid_nxt    = 1'b1;
                        w_id_instr_nxt    = r_hold_instr;
                        w_id_pc_nxt       = r_hold_pc;
                        w_id_pc_plus4_nxt = w_hold_pc_plus4;
                        w_state_nxt       = S_REQ;
                    end
                end
                default: begin
                    // S_DROP: returning data belongs to the squashed path
                    if (w_ack) begin
                        w_state_nxt = S_REQ;
                    end
                    if (!stall) begin
                        w_id_valid_nxt = 1'b0;
                        w_id_instr_nxt = NOP_INSTR;
                    end
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_drop_addr   <= RESET_PC;
            r_hold_instr  <= NOP_INSTR;
            r_hold_pc     <= 32'd0;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 32'd0;
            r_id_pc_plus4 <= 32'd4;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drop_addr   <= w_drop_addr_nxt;
            r_hold_instr  <= w_hold_instr_nxt;
            r_hold_pc     <= w_hold_pc_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Drives the IF/ID pipeline register (instruction, PC, PC+4, valid) that the decoder reads.
- Handles hazard stalls and branch/jump redirects. At most one memory request is outstanding at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented when IF/ID is invalid

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID contents
redirect  input  1  taken branch/JAL/JALR resolved downstream
redirect_pc  input  32  target PC, valid when redirect=1
imem_req  output  1  request valid; address and request held stable until imem_ack
imem_addr  output  32  word-aligned fetch address
imem_ack  input  1  response strobe, sampled only while imem_req=1
imem_rdata  input  32  instruction, valid in the imem_ack cycle
id_valid  output  1  IF/ID register holds a real instruction
id_instruction  output  32  IF/ID instruction, NOP_INSTR when id_valid=0
id_pc  output  32  PC of id_instruction
id_pc_plus4  output  32  id_pc+4

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state=BOOT, pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - id_valid=0, id_instruction=NOP_INSTR, id_pc=0, id_pc_plus4=4
  - hold buffer cleared
  - reset overrides every other input in the same cycle.
- imem_req=1 in REQ and DROP only. imem_addr=pc, except in DROP, where it is drop_addr (the address of the cancelled request).
- States:
  - BOOT: -> REQ next cycle. No request.
  - REQ, imem_ack=1, no redirect, stall=0: load IF/ID (id_valid=1, instruction=imem_rdata, id_pc=pc, id_pc_plus4=pc+4); pc<=pc+4; stay REQ. This gives zero-bubble back-to-back fetch.
  - REQ, imem_ack=1, no redirect, stall=1: capture imem_rdata and pc into the hold buffer; pc<=pc+4; IF/ID unchanged; -> HOLD.
  - REQ, imem_ack=0, no redirect: wait. If stall=0, id_valid<=0 (bubble). If stall=1, IF/ID holds.
  - HOLD: imem_req=0. When stall=0, move the hold buffer into IF/ID (id_valid=1) and -> REQ. While stall=1, stay.
  - DROP: keep the cancelled request alive. When imem_ack arrives, discard the data and -> REQ. While stall=0, id_valid<=0.
- Redirect has priority over stall and over an ack in the same cycle:
  - pc<=redirect_pc, id_valid<=0, hold buffer discarded.
  - From REQ with imem_ack=1: data discarded -> REQ.
  - From REQ with imem_ack=0: drop_addr<=pc -> DROP.
  - From HOLD: -> REQ.
  - From DROP: pc updated, stay DROP; a later redirect supersedes an earlier one.
- Arithmetic:
  - PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - redirect_pc[1:0] is forced to 00.
- The IF/ID register updates only under the rules above. id_instruction is driven from a register, with no combinational path from imem_rdata.
- Reset mid-request: the outstanding request is abandoned. The memory must tolerate imem_req dropping after reset.

Test Plan:
- Reset, then imem_ack tied 1, rdata = address:
  - BOOT cycle shows imem_req=0.
  - Then imem_addr steps 0,4,8,...
  - id_valid=1 from the 3rd cycle after reset release, with id_instruction == id_pc.
- Ack with stall=1 at pc=0x8, stall held 3 cycles:
  - IF/ID holds the pc=0x4 entry and imem_req=0 during HOLD.
  - After stall drops, id_pc=0x8 for one cycle, then fetch resumes at 0xC.
- Ack delayed 3 cycles at pc=0x10; redirect to 0x200 in the first wait cycle:
  - imem_addr stays 0x10 until ack, and that data never reaches IF/ID.
  - Next request is at 0x200; the first valid id_pc is 0x200.
- redirect=1, stall=1 and imem_ack=1 in the same cycle:
  - id_valid=0 next cycle, and the next request address is redirect_pc.
- Redirect to 0xFFFF_FFFC, ack continuously:
  - id_pc sequence 0xFFFF_FFFC then 0x0, with id_pc_plus4 of the first entry = 0x0.
- Assert reset during DROP:
  - Next cycle state BOOT, id_valid=0, id_instruction=0x0000_0013, pc=RESET_PC.
